// File: rtl/alu_pkg.sv
// Shared constants and types for the execute-stage ALU sequencer.
package alu_pkg;

    // ALUOp field encodings
    localparam logic [1:0] ALUOP_MOVI  = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ILL   = 2'b11;

    // R-type funct encodings
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100100;
    localparam logic [5:0] FN_MULT = 6'b100001;
    localparam logic [5:0] FN_DIV  = 6'b100010;
    localparam logic [5:0] FN_MOV  = 6'b100011;

    // alu_control codes
    localparam logic [3:0] CTL_ADD  = 4'b0010;
    localparam logic [3:0] CTL_SUB  = 4'b0110;
    localparam logic [3:0] CTL_MULT = 4'b1000;
    localparam logic [3:0] CTL_DIV  = 4'b1001;
    localparam logic [3:0] CTL_MOV  = 4'b1010;
    localparam logic [3:0] CTL_MOVI = 4'b1011;
    localparam logic [3:0] CTL_NOP  = 4'b1111;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv
    } alu_state_e;

endpackage

// File: rtl/alu_md_iter.sv
// Shared iterative datapath: shift-add multiplier and restoring divider, one bit per step.
// After start, WIDTH steps are needed; done is high on the step that produces the final value,
// and res_lo/res_hi carry that final value in the same cycle.
module alu_md_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  logic             mode,     // 0 multiply, 1 divide
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    // hi_q: partial product high half / partial remainder
    // lo_q: multiplier being shifted out / dividend shifting into quotient
    logic [WIDTH-1:0] hi_q, lo_q, b_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;

    // One multiply or divide step from the current registers
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH + 1){1'b0}});
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        if (mode) begin
            // Top bit of the difference set means the trial subtraction went negative
            if (!div_diff[WIDTH]) begin
                hi_nxt = div_diff[WIDTH-1:0];
                lo_nxt = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = div_shift[WIDTH-1:0];
                lo_nxt = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_nxt = mul_sum[WIDTH:1];
            lo_nxt = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    assign done   = (cnt_q == '0);
    assign res_lo = lo_nxt;
    assign res_hi = hi_nxt;

    // Operand load on start, then one step per cycle while the sequencer is iterating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            cnt_q <= '0;
        end else if (start) begin
            hi_q  <= '0;
            lo_q  <= op_a;
            b_q   <= op_b;
            cnt_q <= CNT_W'(WIDTH - 1);
        end else if (step) begin
            hi_q <= hi_nxt;
            lo_q <= lo_nxt;
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_exec_seq.sv
// Execute-stage ALU: decode, single-cycle ops, iterative MULT/DIV sequencing and a registered
// output stage behind valid/ready handshakes.
module alu_exec_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned FUNCT_W = 6,
    parameter int unsigned CW      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         alu_op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [WIDTH-1:0]   result_hi,
    output logic [CW-1:0]      alu_control,
    output logic               div_by_zero,
    output logic               illegal_op,
    output logic               busy
);

    alu_state_e       state_q;
    logic             accept;
    logic [3:0]       dec_ctl;
    logic [WIDTH-1:0] dec_lo, dec_hi;
    logic             dec_ill, dec_dbz, dec_mul, dec_div;
    logic             md_start, md_step, md_done;
    logic [WIDTH-1:0] md_lo, md_hi;

    assign in_ready = (state_q == StIdle) && (!out_valid || out_ready);
    assign busy     = (state_q != StIdle);
    // Offers made during a flush cycle are dropped
    assign accept   = in_valid && in_ready && !flush;

    // Decode the offered operation and compute single-cycle results
    always_comb begin
        dec_ctl = CTL_NOP;
        dec_lo  = '0;
        dec_hi  = '0;
        dec_ill = 1'b0;
        dec_dbz = 1'b0;
        dec_mul = 1'b0;
        dec_div = 1'b0;
        unique case (alu_op)
            ALUOP_MOVI: begin
                dec_ctl = CTL_MOVI;
                dec_lo  = op_b;
            end
            ALUOP_SUB: begin
                dec_ctl = CTL_SUB;
                dec_lo  = op_a - op_b;
            end
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_W'(FN_ADD): begin
                        dec_ctl = CTL_ADD;
                        dec_lo  = op_a + op_b;
                    end
                    FUNCT_W'(FN_SUB): begin
                        dec_ctl = CTL_SUB;
                        dec_lo  = op_a - op_b;
                    end
                    FUNCT_W'(FN_MULT): begin
                        dec_ctl = CTL_MULT;
                        dec_mul = 1'b1;
                    end
                    FUNCT_W'(FN_DIV): begin
                        dec_ctl = CTL_DIV;
                        if (op_b == '0) begin
                            // Divide by zero completes immediately without iterating
                            dec_lo  = '1;
                            dec_hi  = op_a;
                            dec_dbz = 1'b1;
                        end else begin
                            dec_div = 1'b1;
                        end
                    end
                    FUNCT_W'(FN_MOV): begin
                        dec_ctl = CTL_MOV;
                        dec_lo  = op_a;
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end

    assign md_start = accept && (dec_mul || dec_div);
    assign md_step  = busy && !flush;

    alu_md_iter #(
        .WIDTH(WIDTH)
    ) u_md_iter (
        .clk   (clk),
        .rst_n (rst_n),
        .start (md_start),
        .step  (md_step),
        .mode  (state_q == StDiv),
        .op_a  (op_a),
        .op_b  (op_b),
        .done  (md_done),
        .res_lo(md_lo),
        .res_hi(md_hi)
    );

    // Sequencer FSM and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            out_valid   <= 1'b0;
            result      <= '0;
            result_hi   <= '0;
            alu_control <= CW'(CTL_NOP);
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
        end else if (flush) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (dec_mul || dec_div) begin
                            // Accept implies the output was empty or drained this cycle
                            state_q   <= dec_mul ? StMul : StDiv;
                            out_valid <= 1'b0;
                        end else begin
                            out_valid   <= 1'b1;
                            result      <= dec_lo;
                            result_hi   <= dec_hi;
                            alu_control <= dec_ill ? CW'(CTL_NOP) : CW'(dec_ctl);
                            div_by_zero <= dec_dbz;
                            illegal_op  <= dec_ill;
                        end
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                StMul, StDiv: begin
                    if (md_done) begin
                        state_q     <= StIdle;
                        out_valid   <= 1'b1;
                        result      <= md_lo;
                        result_hi   <= md_hi;
                        alu_control <= (state_q == StMul) ? CW'(CTL_MULT) : CW'(CTL_DIV);
                        div_by_zero <= 1'b0;
                        illegal_op  <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Self-checking bench for alu_exec_seq: directed cases with literal expectations, then random
// traffic compared every cycle against a transaction-level model.
module tb_alu_exec_seq;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    alu_op = 2'b00;
    logic [5:0]    funct = 6'b0;
    logic [W-1:0]  op_a = '0;
    logic [W-1:0]  op_b = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  result, result_hi;
    logic [3:0]    alu_control;
    logic          div_by_zero, illegal_op, busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    alu_exec_seq #(
        .WIDTH  (W),
        .FUNCT_W(6),
        .CW     (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_op     (alu_op),
        .funct      (funct),
        .op_a       (op_a),
        .op_b       (op_b),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .result_hi  (result_hi),
        .alu_control(alu_control),
        .div_by_zero(div_by_zero),
        .illegal_op (illegal_op),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what an accepted operation must produce and after how many cycles
    task automatic model_op(input logic [1:0] op, input logic [5:0] fn,
                            input logic [31:0] a, input logic [31:0] b,
                            output int lat, output logic [31:0] r, output logic [31:0] h,
                            output logic [3:0] c, output logic z, output logic il);
        logic [63:0] p;
        lat = 1; r = 0; h = 0; c = 4'hF; z = 0; il = 0;
        if (op == 2'b00) begin
            r = b; c = 4'b1011;
        end else if (op == 2'b01) begin
            r = a - b; c = 4'b0110;
        end else if (op == 2'b10) begin
            case (fn)
                6'b100000: begin r = a + b; c = 4'b0010; end
                6'b100100: begin r = a - b; c = 4'b0110; end
                6'b100001: begin
                    p = {32'b0, a} * {32'b0, b};
                    r = p[31:0]; h = p[63:32]; c = 4'b1000; lat = W + 1;
                end
                6'b100010: begin
                    c = 4'b1001;
                    if (b == 0) begin r = 32'hFFFF_FFFF; h = a; z = 1; end
                    else begin r = a / b; h = a % b; lat = W + 1; end
                end
                6'b100011: begin r = a; c = 4'b1010; end
                default: il = 1;
            endcase
        end else begin
            il = 1;
        end
    endtask

    // Model state: output register contents and a pending multi-cycle result
    logic        m_full = 0, m_pend = 0;
    int          m_cnt = 0;
    logic [31:0] m_res = 0, m_hi = 0, p_res = 0, p_hi = 0;
    logic [3:0]  m_ctl = 4'hF, p_ctl = 4'hF;
    logic        m_dbz = 0, m_ill = 0;

    initial forever begin
        int lat;
        logic [31:0] r, h;
        logic [3:0] c;
        logic z, il;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_full = 0; m_pend = 0; m_res = 0; m_hi = 0; m_ctl = 4'hF; m_dbz = 0; m_ill = 0;
        end else if (flush) begin
            m_full = 0; m_pend = 0;
        end else if (m_pend) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_pend = 0; m_full = 1;
                m_res = p_res; m_hi = p_hi; m_ctl = p_ctl; m_dbz = 0; m_ill = 0;
            end
        end else if (in_valid && (!m_full || out_ready)) begin
            model_op(alu_op, funct, op_a, op_b, lat, r, h, c, z, il);
            if (lat == 1) begin
                m_full = 1; m_res = r; m_hi = h; m_ctl = c; m_dbz = z; m_ill = il;
            end else begin
                m_full = 0; m_pend = 1; m_cnt = lat - 1; p_res = r; p_hi = h; p_ctl = c;
            end
        end else if (m_full && out_ready) begin
            m_full = 0;
        end
    end

    // Per-cycle compare against the model, away from the active edge
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("out_valid", out_valid, m_full);
            check("in_ready", in_ready, !m_pend && (!m_full || out_ready));
            check("busy", busy, m_pend);
            if (m_full || !rst_n) begin
                check("result", result, m_res);
                check("result_hi", result_hi, m_hi);
                check("alu_control", alu_control, m_ctl);
                check("div_by_zero", div_by_zero, m_dbz);
                check("illegal_op", illegal_op, m_ill);
            end
        end
    end

    // Offer an op starting at posedge+2; returns at posedge+2 of the accepting edge
    task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b);
        bit acc = 0;
        in_valid = 1; alu_op = op; funct = fn; op_a = a; op_b = b;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready && !flush;
            @(posedge clk);
            #2;
        end
        in_valid = 0;
        check("issue_accept", acc, 1);
    endtask

    // Latency in cycles after accept; stall_ok tracks in_ready=0/busy=1 while waiting
    task automatic wait_out(output int lat, output bit stall_ok);
        lat = 1;
        stall_ok = 1;
        while (!out_valid && lat < 100) begin
            if (in_ready || !busy) stall_ok = 0;
            @(posedge clk);
            #2;
            lat++;
        end
    endtask

    initial begin
        int lat;
        bit ok, saw;
        logic [5:0] fn_tab [6];
        fn_tab[0] = 6'b100000; fn_tab[1] = 6'b100100; fn_tab[2] = 6'b100001;
        fn_tab[3] = 6'b100010; fn_tab[4] = 6'b100011; fn_tab[5] = 6'b111111;

        @(posedge clk);
        #2;
        chk_en = 1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_ctl", alu_control, 4'hF);
        check("rst_result", result, 0);
        @(posedge clk);
        #2;
        rst_n = 1;
        @(posedge clk);
        #2;

        // 1: back-to-back ADD then SUB
        issue(2'b10, 6'b100000, 32'd7, 32'd5);
        check("add_result", result, 32'h0000_000C);
        check("add_ctl", alu_control, 4'b0010);
        check("add_valid", out_valid, 1);
        issue(2'b10, 6'b100100, 32'd5, 32'd7);
        check("sub_result", result, 32'hFFFF_FFFE);
        check("sub_ctl", alu_control, 4'b0110);
        check("sub_valid", out_valid, 1);
        @(posedge clk);
        #2;

        // 2: MULT
        issue(2'b10, 6'b100001, 32'hFFFF_FFFF, 32'd2);
        wait_out(lat, ok);
        check("mult_latency", lat, 33);
        check("mult_stall", ok, 1);
        check("mult_lo", result, 32'hFFFF_FFFE);
        check("mult_hi", result_hi, 32'h1);
        check("mult_ctl", alu_control, 4'b1000);
        @(posedge clk);
        #2;

        // 3: DIV and divide by zero
        issue(2'b10, 6'b100010, 32'd100, 32'd7);
        wait_out(lat, ok);
        check("div_latency", lat, 33);
        check("div_q", result, 32'd14);
        check("div_r", result_hi, 32'd2);
        check("div_dbz", div_by_zero, 0);
        @(posedge clk);
        #2;
        issue(2'b10, 6'b100010, 32'd100, 32'd0);
        wait_out(lat, ok);
        check("div0_latency", lat, 1);
        check("div0_q", result, 32'hFFFF_FFFF);
        check("div0_r", result_hi, 32'd100);
        check("div0_flag", div_by_zero, 1);
        @(posedge clk);
        #2;

        // 4: output held under backpressure, then illegal funct
        out_ready = 0;
        issue(2'b00, 6'b000000, 32'hDEAD_BEEF, 32'h1234);
        for (int i = 0; i < 5; i++) begin
            check("hold_result", result, 32'h1234);
            check("hold_in_ready", in_ready, 0);
            check("hold_valid", out_valid, 1);
            @(posedge clk);
            #2;
        end
        out_ready = 1;
        issue(2'b10, 6'b111111, 32'd3, 32'd4);
        check("ill_flag", illegal_op, 1);
        check("ill_result", result, 0);
        check("ill_ctl", alu_control, 4'hF);
        check("ill_dbz", div_by_zero, 0);
        @(posedge clk);
        #2;

        // 5: flush on cycle 10 of DIV, then ADD
        issue(2'b10, 6'b100010, 32'd1000, 32'd3);
        repeat (9) begin @(posedge clk); #2; end
        flush = 1;
        @(posedge clk);
        #2;
        flush = 0;
        saw = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) saw = 1;
            @(posedge clk);
            #2;
        end
        check("flush_no_valid", saw, 0);
        check("flush_busy", busy, 0);
        issue(2'b10, 6'b100000, 32'd1, 32'd1);
        check("post_flush_add", result, 32'd2);
        check("post_flush_valid", out_valid, 1);
        @(posedge clk);
        #2;

        // 6: async reset mid-MULT
        issue(2'b10, 6'b100001, 32'h1234, 32'h5678);
        repeat (5) begin @(posedge clk); #2; end
        rst_n = 0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_result", result, 0);
        check("arst_result_hi", result_hi, 0);
        check("arst_ctl", alu_control, 4'hF);
        check("arst_flags", {div_by_zero, illegal_op}, 0);
        repeat (2) begin @(posedge clk); #2; end
        rst_n = 1;
        @(posedge clk);
        #2;
        check("arst_in_ready", in_ready, 1);
        check("arst_no_valid", out_valid, 0);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 9);
            alu_op   = (r < 1) ? 2'b00 : (r < 2) ? 2'b01 : (r < 3) ? 2'b11 : 2'b10;
            r = $urandom_range(0, 6);
            funct    = (r == 6) ? 6'($urandom) : fn_tab[r];
            op_a     = $urandom;
            if ($urandom_range(0, 7) == 0) op_b = 0;
            else if ($urandom_range(0, 1) == 1) op_b = $urandom;
            else op_b = $urandom_range(0, 50);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            @(posedge clk);
            #2;
        end
        in_valid = 0;
        flush = 0;
        out_ready = 1;
        repeat (40) begin @(posedge clk); #2; end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
